// File: rtl/ble_cmd_rcv_if.sv
// Bus bundle between the BLE command receiver and its environment.
// The frm_err strobe is only present when FRAME_ERR_EN is defined.
interface ble_cmd_rcv_if;
   logic       RX;
   logic       clr_rdy;
   logic       rider_off;
   logic [7:0] rx_data;
   logic       rdy;
   logic       rx_done;
   logic       pwr_up;
`ifdef FRAME_ERR_EN
   logic       frm_err;

   modport master (
      output RX, clr_rdy, rider_off,
      input  rx_data, rdy, rx_done, pwr_up, frm_err
   );
   modport slave (
      input  RX, clr_rdy, rider_off,
      output rx_data, rdy, rx_done, pwr_up, frm_err
   );
`else
   modport master (
      output RX, clr_rdy, rider_off,
      input  rx_data, rdy, rx_done, pwr_up
   );
   modport slave (
      input  RX, clr_rdy, rider_off,
      output rx_data, rdy, rx_done, pwr_up
   );
`endif
endinterface

// File: rtl/ble_cmd_rcv.sv
// UART 8N1 receiver plus power-up authorization FSM for the BLE command link.
// Define FRAME_ERR_EN to discard bytes with a bad stop bit and pulse frm_err.
module ble_cmd_rcv #(
   parameter int         BAUD_CYCLES = 2604,
   parameter logic [7:0] GO_CMD      = 8'h47,
   parameter logic [7:0] STOP_CMD    = 8'h53
) (
   input  logic         clk,
   input  logic         rst_n,
   ble_cmd_rcv_if.slave bus
);

   localparam logic [11:0] HALF_LD = 12'(BAUD_CYCLES / 2 - 1);
   localparam logic [11:0] FULL_LD = 12'(BAUD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

   logic        rx_m, rx_s, rx_prev;
   rx_state_t   rx_state, rx_nxt;
   auth_state_t auth_state, auth_nxt;
   logic [11:0] bcnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        bcnt_zero;
   logic        ld_half, ld_full, clr_idx, shift_en, byte_good, frame_bad;
   logic [7:0]  rx_data_r;
   logic        rdy_r, rx_done_r, frm_err_r, pwr_up_r, pwr_nxt;

   // RX is asynchronous; two flops for metastability, a third for edge detect
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= bus.RX;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   assign bcnt_zero = (bcnt == 12'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) rx_state <= IDLE;
      else        rx_state <= rx_nxt;
   end

   always_comb begin
      rx_nxt = rx_state;
      case (rx_state)
         IDLE:  if (rx_prev && !rx_s) rx_nxt = START;
         START: if (bcnt_zero) rx_nxt = rx_s ? IDLE : DATA;
         DATA:  if (bcnt_zero && bit_idx == 3'd7) rx_nxt = STOP;
         STOP:  if (bcnt_zero) rx_nxt = IDLE;
         default: rx_nxt = IDLE;
      endcase
   end

   always_comb begin
      ld_half   = 1'b0;
      ld_full   = 1'b0;
      clr_idx   = 1'b0;
      shift_en  = 1'b0;
      byte_good = 1'b0;
      frame_bad = 1'b0;
      case (rx_state)
         IDLE:  ld_half = rx_prev && !rx_s;
         START: begin
            ld_full = bcnt_zero && !rx_s;
            clr_idx = bcnt_zero && !rx_s;
         end
         DATA: begin
            ld_full  = bcnt_zero;
            shift_en = bcnt_zero;
         end
         STOP: begin
`ifdef FRAME_ERR_EN
            byte_good = bcnt_zero && rx_s;
            frame_bad = bcnt_zero && !rx_s;
`else
            byte_good = bcnt_zero;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcnt    <= 12'd0;
         bit_idx <= 3'd0;
      end else begin
         if (ld_half)                          bcnt <= HALF_LD;
         else if (ld_full)                     bcnt <= FULL_LD;
         else if (rx_state != IDLE && !bcnt_zero) bcnt <= bcnt - 12'd1;
         if (clr_idx)       bit_idx <= 3'd0;
         else if (shift_en) bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
   end

   // Byte completion takes priority over a simultaneous clr_rdy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data_r <= 8'h00;
         rdy_r     <= 1'b0;
         rx_done_r <= 1'b0;
         frm_err_r <= 1'b0;
      end else begin
         rx_done_r <= byte_good;
         frm_err_r <= frame_bad;
         if (byte_good) rx_data_r <= shreg;
         if (byte_good)        rdy_r <= 1'b1;
         else if (bus.clr_rdy) rdy_r <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) auth_state <= OFF;
      else        auth_state <= auth_nxt;
   end

   always_comb begin
      auth_nxt = auth_state;
      case (auth_state)
         OFF:  if (rx_done_r && rx_data_r == GO_CMD) auth_nxt = PWR1;
         PWR1: if (rx_done_r && rx_data_r == STOP_CMD) auth_nxt = bus.rider_off ? OFF : PWR2;
         PWR2: begin
            if (rx_done_r && rx_data_r == GO_CMD) auth_nxt = PWR1;
            else if (bus.rider_off)              auth_nxt = OFF;
         end
         default: auth_nxt = OFF;
      endcase
   end

   always_comb begin
      pwr_nxt = (auth_nxt == PWR1) || (auth_nxt == PWR2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pwr_up_r <= 1'b0;
      else        pwr_up_r <= pwr_nxt;
   end

   assign bus.rx_data = rx_data_r;
   assign bus.rdy     = rdy_r;
   assign bus.rx_done = rx_done_r;
   assign bus.pwr_up  = pwr_up_r;
`ifdef FRAME_ERR_EN
   assign bus.frm_err = frm_err_r;
`else
   logic unused_frm;
   assign unused_frm = frm_err_r ^ frame_bad;
`endif

endmodule
